// File: rtl/csmulti_arbiter.sv
// csmulti_arbiter: round-robin sharing of one 8x8 carry-save multiplier among
// NUM_REQ requesters. Operands are registered and held for SETTLE_CYCLES so
// the multiplier can be timed as a multicycle path; the registered product is
// returned with the owning requester's ID over a valid/ready channel.

// Combinational 8x8 unsigned multiplier: carry-save reduction of the partial
// products followed by a single carry-propagate add.
module csmulti_fullbasecell (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);

  logic [15:0] sum_v;
  logic [15:0] carry_v;
  logic [15:0] pp;
  logic [15:0] t;

  // Fold each partial product into the sum/carry pair with a 3:2 compressor row
  always_comb begin
    pp      = '0;
    t       = '0;
    sum_v   = {8'b0, a & {8{b[0]}}};
    carry_v = '0;
    for (int i = 1; i < 8; i++) begin
      pp      = {8'b0, a & {8{b[i]}}} << i;
      t       = sum_v ^ carry_v ^ pp;
      carry_v = ((sum_v & carry_v) | (sum_v & pp) | (carry_v & pp)) << 1;
      sum_v   = t;
    end
    product = sum_v + carry_v;
  end

endmodule

module csmulti_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int SETTLE_CYCLES = 2,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_product,
  output logic                 busy
);

  // Counter only needs to reach SETTLE_CYCLES-1
  localparam int              CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IDW-1:0]  PTR_INIT = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  op_id;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [CW-1:0]   cnt;
  logic [15:0]     mul_product;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [7:0]      grant_a;
  logic [7:0]      grant_b;
  logic [IDW-1:0]  idx_t;
  int              idx_w;
  logic            accept;

  csmulti_fullbasecell u_mul (
    .a       (op_a),
    .b       (op_b),
    .product (mul_product)
  );

  // Round-robin search starting just after the last grant; walking the
  // offsets downward lets the nearest valid requester win
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_a     = '0;
    grant_b     = '0;
    idx_w       = 0;
    idx_t       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_w = (int'(rr_ptr) + k) % NUM_REQ;
      idx_t = IDW'(idx_w);
      if (req_valid[idx_t]) begin
        grant_found = 1'b1;
        grant_idx   = idx_t;
        grant_a     = req_a[{idx_t, 3'b000} +: 8];
        grant_b     = req_b[{idx_t, 3'b000} +: 8];
      end
    end
  end

  // Handshake toward requesters: only the winner, only while idle
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = (state == S_IDLE) && grant_found;
  assign busy   = (state != S_IDLE);

  // Operation sequencer: accept, hold operands while the product settles, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= PTR_INIT;
      op_id       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a   <= grant_a;
            op_b   <= grant_b;
            op_id  <= grant_idx;
            rr_ptr <= grant_idx;
            cnt    <= '0;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            rsp_product <= mul_product;
            rsp_id      <= op_id;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/csmulti_arbiter.md
Name: csmulti_arbiter

Overview:
Shares one 8x8 carry-save multiplier instance (csmulti_fullbasecell, combinational, 16-bit product) among NUM_REQ requesters. Round-robin arbitration with a valid/ready request handshake per requester. Registers the operands and waits a fixed number of settle cycles so the multiplier is timed as a multicycle path. Returns the registered product with a requester ID over a single valid/ready response channel.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
SETTLE_CYCLES, 2, cycles the multiplier inputs are held before the product is sampled; must be >= 1.
IDW, $clog2(NUM_REQ), width of the requester ID. Derived; not to be overridden.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  bit i: requester i has operands pending
req_ready  out  NUM_REQ  bit i: requester i granted and accepted this cycle
req_a  in  8*NUM_REQ  multiplicand; requester i uses bits [8i+7:8i]
req_b  in  8*NUM_REQ  multiplier; requester i uses bits [8i+7:8i]
rsp_valid  out  1  product valid
rsp_ready  in  1  consumer accepts product
rsp_id  out  IDW  index of the requester that owns rsp_product
rsp_product  out  16  unsigned product a*b
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, any state): state=IDLE, rsp_valid=0, rsp_id=0, rsp_product=0, operand regs=0, settle counter=0, RR pointer=NUM_REQ-1, so requester 0 has first priority. No pending response survives reset.
- States: IDLE, SETTLE, RESP.
- IDLE: grant g = first i with req_valid[i]=1, searching from pointer+1 upward with wrap-around. req_ready is combinational: only bit g is high, and only in IDLE with a valid request. All bits are 0 in SETTLE and RESP. On the edge with req_valid[g]&&req_ready[g]: latch req_a/req_b slices of g into op_a/op_b, latch id=g, set pointer=g, clear counter, go to SETTLE.
- Multiplier inputs come only from op_a/op_b, which are stable for the whole operation.
- SETTLE: counter increments each edge. On the edge where counter==SETTLE_CYCLES-1: register the multiplier output into rsp_product, id into rsp_id, set rsp_valid=1, go to RESP.
- Latency: rsp_valid rises SETTLE_CYCLES edges after the accept edge.
- RESP: rsp_valid, rsp_id and rsp_product are held stable until rsp_valid&&rsp_ready at an edge. On that edge: rsp_valid=0, go to IDLE. rsp_product/rsp_id keep their last value. No new accept in the same cycle.
- Throughput: with rsp_ready held high, one operation every SETTLE_CYCLES+2 cycles.
- A requester may drop req_valid before it is granted; no lock is held. Requesters must keep their operands stable while req_valid is high.
- Requests arriving while busy wait; arbitration is re-evaluated in IDLE only.
- Arithmetic: unsigned, full 16-bit result, no truncation; 255*255=65025.

Test Plan:
1. Reset, then req_valid=0001 with a0=255, b0=255, rsp_ready=1 -> req_ready=0001 at accept edge E; rsp_valid=1 after E+2; rsp_product=65025, rsp_id=0; IDLE at E+3.
2. All valid together: (150,100), (23,45), (11,243), (121,212) for requesters 0..3, rsp_ready=1 -> grant order 0,1,2,3; products 15000, 1035, 2673, 25652 with ids 0..3; accepts exactly 4 cycles apart.
3. Fairness: requesters 1 and 3 held valid continuously, pointer starting at 3 -> grant sequence 1,3,1,3; requesters 0 and 2 never granted.
4. Backpressure: requester 2 sends (88,25), rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid stays 1, product 2200 and id 2 stable, req_ready=0000 despite pending req_valid[0], busy=1. rsp_ready=1 -> released, next grant goes to requester 0.
5. Reset mid-operation: requester 1 sends (96,231), rst pulsed during SETTLE -> all outputs 0 immediately, no response emitted. After release, the same request is re-accepted and yields 22176 with id 1; requester 0 wins if it is also valid.
6. Boundaries: (1,255) -> 255; (0,200) -> 0; SETTLE_CYCLES=1 build -> rsp_valid one edge after accept.
